// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, GF(2^8) helpers and decrypt FSM state type
//
// Purpose: S-box tables, round constants and byte-level helper functions shared
// by the folded decrypt core and its round datapath.
// Byte order everywhere: bit 127 is byte 0, bytes are column-major
// (byte 4*col+row sits at bits [127-8*(4*col+row) -: 8]).
package aes_pkg;

   typedef enum logic [2:0] {NOKEY, KEYEXP, IDLE, ROUND, DONE} state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

   // Indexed directly by round number 1..10; the unused slots read as zero.
   localparam logic [7:0] RCON [16] = '{
      8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Row r rotates right by r columns.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
         o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
         o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
         o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round
//
// Purpose: one inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
// Ports:
//   state_i       in  128  current cipher state
//   round_key_i   in  128  round key added in this round
//   last_i        in  1    final round, skip InvMixColumns
//   next_state_o  out 128  state after this round
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         last_i,
   output logic [127:0] next_state_o
);

   logic [127:0] shifted;
   logic [127:0] subbed;
   logic [127:0] keyed;

   always_comb begin
      shifted = inv_shift_rows(state_i);
      subbed  = '0;
      for (int b = 0; b < 16; b++) begin
         subbed[8*b +: 8] = INV_SBOX[shifted[8*b +: 8]];
      end
      keyed        = subbed ^ round_key_i;
      next_state_o = last_i ? keyed : inv_mix_columns(keyed);
   end

endmodule

// File: rtl/aes_iter_decrypt.sv
// rtl/aes_iter_decrypt.sv - folded AES-128 inverse cipher, one round per clock
//
// Purpose: expands a loaded key forward once to K10, then decrypts blocks in
// ten cycles each while regenerating round keys backwards from K10.
// Ports:
//   clk_i        in  1    clock, rising edge
//   rstn_i       in  1    asynchronous active-low reset
//   key_i        in  128  cipher key
//   key_load_i   in  1    load key_i (honoured in NOKEY/IDLE only)
//   key_ready_o  out 1    last round key valid
//   cipher_i     in  128  ciphertext block
//   in_valid_i   in  1    cipher_i valid
//   in_ready_o   out 1    core accepts a block (IDLE only)
//   text_o       out 128  plaintext, held while out_valid_o is high
//   out_valid_o  out 1    text_o valid
//   out_ready_i  in  1    downstream accepts text_o
module aes_iter_decrypt
   import aes_pkg::*;
(
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic [127:0] key_i,
   input  logic         key_load_i,
   output logic         key_ready_o,
   input  logic [127:0] cipher_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   output logic [127:0] text_o,
   output logic         out_valid_o,
   input  logic         out_ready_i
);

   state_e       st_q, st_d;
   logic [3:0]   cnt_q, cnt_d;          // key-expansion step or current round number
   logic [127:0] key_q, key_d;          // working key: K(cnt-1) in KEYEXP, K(cnt) in ROUND
   logic [127:0] k10_q, k10_d;
   logic [127:0] data_q, data_d;
   logic [127:0] text_q, text_d;
   logic         key_ready_q, key_ready_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;

   logic [31:0]  rcon_w;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  f0, f1, f2, f3;
   logic [31:0]  v0, v1, v2, v3;
   logic [127:0] key_fwd, key_inv;
   logic [127:0] round_out;

   // Forward and inverse key-schedule steps share one RCON lookup by cnt_q.
   always_comb begin
      rcon_w = {RCON[cnt_q], 24'h000000};
      {w0, w1, w2, w3} = key_q;
      f0 = w0 ^ sub_word(rot_word(w3)) ^ rcon_w;
      f1 = w1 ^ f0;
      f2 = w2 ^ f1;
      f3 = w3 ^ f2;
      key_fwd = {f0, f1, f2, f3};
      v3 = w3 ^ w2;
      v2 = w2 ^ w1;
      v1 = w1 ^ w0;
      v0 = w0 ^ sub_word(rot_word(v3)) ^ rcon_w;
      key_inv = {v0, v1, v2, v3};
   end

   aes_inv_round u_round (
      .state_i      (data_q),
      .round_key_i  (key_inv),
      .last_i       (cnt_q == 4'd1),
      .next_state_o (round_out)
   );

   always_comb begin
      st_d        = st_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      k10_d       = k10_q;
      data_d      = data_q;
      text_d      = text_q;
      key_ready_d = key_ready_q;
      out_valid_d = out_valid_q;
      case (st_q)
         NOKEY, IDLE: begin
            // A key load takes priority over a block offered in the same cycle.
            if (key_load_i) begin
               key_d       = key_i;
               cnt_d       = 4'd1;
               key_ready_d = 1'b0;
               st_d        = KEYEXP;
            end else if (st_q == IDLE && in_valid_i && in_ready_q) begin
               data_d = cipher_i ^ k10_q;
               key_d  = k10_q;
               cnt_d  = 4'd10;
               st_d   = ROUND;
            end
         end
         KEYEXP: begin
            key_d = key_fwd;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd10) begin
               k10_d       = key_fwd;
               key_ready_d = 1'b1;
               st_d        = IDLE;
            end
         end
         ROUND: begin
            data_d = round_out;
            key_d  = key_inv;
            cnt_d  = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               text_d      = round_out;
               out_valid_d = 1'b1;
               st_d        = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               st_d        = IDLE;
            end
         end
         default: st_d = NOKEY;
      endcase
      in_ready_d = (st_d == IDLE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         st_q        <= NOKEY;
         cnt_q       <= '0;
         key_q       <= '0;
         k10_q       <= '0;
         data_q      <= '0;
         text_q      <= '0;
         key_ready_q <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         k10_q       <= k10_d;
         data_q      <= data_d;
         text_q      <= text_d;
         key_ready_q <= key_ready_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign key_ready_o = key_ready_q;
   assign in_ready_o  = in_ready_q;
   assign text_o      = text_q;
   assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_aes_iter_decrypt.sv
// tb/tb_aes_iter_decrypt.sv - self-checking bench for aes_iter_decrypt
module tb_aes_iter_decrypt;

   logic         clk = 1'b0;
   logic         rstn;
   logic [127:0] key;
   logic         key_load;
   logic         key_ready;
   logic [127:0] cipher;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] text;
   logic         out_valid;
   logic         out_ready;

   always #5 clk = ~clk;

   aes_iter_decrypt dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .key_i       (key),
      .key_load_i  (key_load),
      .key_ready_o (key_ready),
      .cipher_i    (cipher),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .text_o      (text),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model: AES-128 encryption from first principles
   logic [7:0]   sb [256];
   logic [127:0] rk_m [11];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   function automatic void build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int x = 1; x < 256; x++) if (a != 0 && gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
         sb[a] = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
      end
   endfunction

   function automatic void expand_key(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] p);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk_m[0][127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gf_mul(a0,2) ^ gf_mul(a1,3) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gf_mul(a1,2) ^ gf_mul(a2,3) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gf_mul(a2,2) ^ gf_mul(a3,3);
               s[4*c+3] = gf_mul(a0,3) ^ a1 ^ a2 ^ gf_mul(a3,2);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_m[r][127-8*i -: 8];
      end
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- drive helpers; all start and end at posedge + 1
   task automatic load_key(input logic [127:0] k);
      key = k; key_load = 1'b1;
      @(posedge clk); #1;
      key_load = 1'b0;
   endtask

   task automatic send(input logic [127:0] c);
      cipher = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_key(output int n);
      n = 0;
      while (n < 40 && !key_ready) begin @(posedge clk); #1; n++; end
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (n < 40 && !out_valid) begin @(posedge clk); #1; n++; end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] k10;
      logic [127:0] pt;
   } vec_t;

   vec_t         vecs [2];
   logic [127:0] pt_r [100];
   logic [127:0] ct_r [100];

   initial begin
      int n, m, sidx, ridx, cyc;
      logic [127:0] k_r;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h3243f6a8885a308d313198a2e0370734};
      build_sbox();

      // Reset with random inputs: every output must stay at zero.
      rstn = 1'b0;
      for (int i = 0; i < 6; i++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         cipher = {$urandom, $urandom, $urandom, $urandom};
         key_load = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("reset_outputs", {key_ready, in_ready, out_valid, text}, '0);
      end
      key_load = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      // No key yet: offered blocks are ignored.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("nokey_ignored", {in_ready, out_valid, key_ready}, '0);
      end
      in_valid = 1'b0;

      // FIPS-197 vectors
      for (int i = 0; i < 2; i++) begin
         load_key(vecs[i].key);
         wait_key(n);
         check("key_latency", 128'(n), 128'd10);
         check("k10", dut.k10_q, vecs[i].k10);
         check("in_ready_idle", 128'(in_ready), 128'd1);
         send(vecs[i].ct);
         wait_out(n);
         check("block_latency", 128'(n), 128'd10);
         check("plaintext", text, vecs[i].pt);
         handshake();
         check("out_valid_drop", 128'(out_valid), 128'd0);
      end

      // Back-pressure on C.1: output held, nothing accepted until the handshake.
      load_key(vecs[0].key);
      wait_key(n);
      send(vecs[0].ct);
      wait_out(n);
      cipher = vecs[0].ct; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("bp_hold", {in_ready, out_valid, text}, {2'b01, vecs[0].pt});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release", {in_ready, out_valid}, 128'b10);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_next_accept", 128'(in_ready), 128'd0);
      wait_out(n);
      check("bp_next_latency", 128'(n), 128'd10);
      check("bp_next_text", text, vecs[0].pt);
      handshake();

      // Key load during ROUND is ignored.
      send(vecs[0].ct);
      @(posedge clk); #1;
      @(posedge clk); #1;
      load_key({$urandom, $urandom, $urandom, $urandom});
      wait_out(n);
      check("kl_round_latency", 128'(n + 3), 128'd10);
      check("kl_round_text", text, vecs[0].pt);
      check("kl_round_k10", dut.k10_q, vecs[0].k10);
      check("kl_round_keyready", 128'(key_ready), 128'd1);
      handshake();

      // Key load and block offered together in IDLE: the load wins.
      key = vecs[1].key; key_load = 1'b1;
      cipher = vecs[0].ct; in_valid = 1'b1;
      @(posedge clk); #1;
      key_load = 1'b0; in_valid = 1'b0;
      check("kl_wins", {in_ready, out_valid, key_ready}, '0);
      wait_key(n);
      check("kl_wins_latency", 128'(n), 128'd10);
      check("kl_wins_k10", dut.k10_q, vecs[1].k10);
      send(vecs[1].ct);
      wait_out(n);
      check("kl_wins_text", text, vecs[1].pt);
      handshake();

      // Reset in the middle of a block.
      send(vecs[1].ct);
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
      #2 rstn = 1'b0;
      #1;
      check("midreset_outputs", {key_ready, in_ready, out_valid, text}, '0);
      check("midreset_k10", dut.k10_q, '0);
      @(posedge clk); #1;
      rstn = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("midreset_nokey", {in_ready, out_valid}, '0);
      end
      in_valid = 1'b0;

      // Random key and 100 blocks with random valid / ready.
      k_r = {$urandom, $urandom, $urandom, $urandom};
      expand_key(k_r);
      for (int i = 0; i < 100; i++) begin
         pt_r[i] = {$urandom, $urandom, $urandom, $urandom};
         ct_r[i] = encrypt(pt_r[i]);
      end
      load_key(k_r);
      wait_key(n);
      check("rand_key_latency", 128'(n), 128'd10);
      sidx = 0; ridx = 0; cyc = 0;
      in_valid = 1'b1; cipher = ct_r[0]; out_ready = 1'($urandom_range(0, 1));
      while (ridx < 100 && cyc < 6000) begin
         @(negedge clk);
         m = (in_valid && in_ready) ? 1 : 0;
         if (out_valid && out_ready) begin
            check("rand_text", text, pt_r[ridx]);
            ridx++;
         end
         @(posedge clk); #1;
         sidx += m;
         in_valid  = (sidx < 100) && ($urandom_range(0, 3) != 0);
         cipher    = ct_r[sidx < 100 ? sidx : 99];
         out_ready = 1'($urandom_range(0, 1));
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("rand_count", 128'(ridx), 128'd100);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
